// File: rtl/riscv_checkpoint_checker.sv
// Checkpoint scoreboard: compares core OUTPUT_PORT against a loadable table of
// (retired-instruction count, expected value) pairs and reports pass/fail, first error, counts.
module riscv_checkpoint_checker #(
  parameter int          NUM_TEST       = 64,
  parameter int          NW             = 32,
  parameter int          DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          STOP_ON_FAIL   = 1'b1,
  localparam int         IW             = $clog2(NUM_TEST)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          LD_WE,
  input  logic [IW-1:0] LD_IDX,
  input  logic [NW-1:0] LD_NUM,
  input  logic [DW-1:0] LD_ANS,
  input  logic [IW:0]   N_ACT,
  input  logic          START,
  input  logic [NW-1:0] NUM_INST,
  input  logic [DW-1:0] OUTPUT_PORT,
  input  logic          HALT,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASSED,
  output logic [2:0]    ERR_CODE,
  output logic [IW-1:0] ERR_IDX,
  output logic [DW-1:0] ERR_GOT,
  output logic [IW:0]   PASS_CNT,
  output logic [31:0]   CYCLE_CNT
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t        state;
  logic [NW-1:0] num_tbl [NUM_TEST];
  logic [DW-1:0] ans_tbl [NUM_TEST];
  logic [IW:0]   ptr;
  logic [IW:0]   n_act;

  logic          in_range;
  logic          hit;
  logic          match;
  logic          ent_err;
  logic [IW:0]   ptr_nxt;
  logic [32:0]   cyc_inc;
  logic          tmo;
  logic [2:0]    log_code;
  logic [IW:0]   log_idx;
  logic          finish;
  logic          pass_now;

  assign BUSY   = (state == RUN);
  assign DONE   = (state == PASS) || (state == FAIL);
  assign PASSED = (state == PASS);

  // Table has no reset so a loaded program survives a checker reset.
  always_ff @(posedge CLK) begin
    if (LD_WE && state != RUN) begin
      num_tbl[LD_IDX] <= LD_NUM;
      ans_tbl[LD_IDX] <= LD_ANS;
    end
  end

  always_comb begin
    in_range = (ptr < n_act);
    hit      = in_range && (NUM_INST == num_tbl[ptr[IW-1:0]]);
    match    = hit && (OUTPUT_PORT == ans_tbl[ptr[IW-1:0]]);
    ent_err  = in_range && !match && (NUM_INST >= num_tbl[ptr[IW-1:0]]);
    ptr_nxt  = (match || (ent_err && !STOP_ON_FAIL)) ? ptr + 1'b1 : ptr;
    cyc_inc  = {1'b0, CYCLE_CNT} + 33'd1;
    tmo      = (TIMEOUT_CYCLES != 0) && (cyc_inc == 33'(TIMEOUT_CYCLES));

    // Entry check outranks HALT, which outranks timeout.
    log_code = 3'd0;
    log_idx  = ptr_nxt;
    if (ent_err) begin
      log_code = hit ? 3'd1 : 3'd2;
      log_idx  = ptr;
    end else if (HALT) begin
      if (ptr_nxt != n_act) log_code = 3'd3;
    end else if (tmo) begin
      log_code = 3'd4;
    end

    finish   = (ent_err && STOP_ON_FAIL) || HALT || tmo;
    pass_now = HALT && (ptr_nxt == n_act) && !ent_err && (ERR_CODE == 3'd0);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      ptr       <= '0;
      n_act     <= '0;
      ERR_CODE  <= '0;
      ERR_IDX   <= '0;
      ERR_GOT   <= '0;
      PASS_CNT  <= '0;
      CYCLE_CNT <= '0;
    end else begin
      case (state)
        RUN: begin
          CYCLE_CNT <= cyc_inc[32] ? CYCLE_CNT : cyc_inc[31:0];
          ptr       <= ptr_nxt;
          if (match) PASS_CNT <= PASS_CNT + 1'b1;
          if (log_code != 3'd0 && ERR_CODE == 3'd0) begin
            ERR_CODE <= log_code;
            ERR_IDX  <= log_idx[IW-1:0];
            ERR_GOT  <= OUTPUT_PORT;
          end
          if (finish) state <= pass_now ? PASS : FAIL;
        end
        default: begin
          if (START) begin
            state     <= RUN;
            ptr       <= '0;
            n_act     <= N_ACT;
            ERR_CODE  <= '0;
            ERR_IDX   <= '0;
            ERR_GOT   <= '0;
            PASS_CNT  <= '0;
            CYCLE_CNT <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_checkpoint_checker.sv
// Bench: two checkers (stop-on-fail with 16-cycle timeout, and continue-on-fail without timeout)
// share one stimulus stream; results are compared against a trace-level reference model.
module tb_riscv_checkpoint_checker;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        passed;
    logic [2:0]  code;
    logic [5:0]  idx;
    logic [31:0] got;
    logic [6:0]  pcnt;
    logic [31:0] cyc;
  } res_t;

  logic        CLK, RSTn, LD_WE, START, HALT;
  logic [5:0]  LD_IDX;
  logic [31:0] LD_NUM, LD_ANS, NUM_INST, OUTPUT_PORT;
  logic [6:0]  N_ACT;

  logic        s_busy, s_done, s_passed, c_busy, c_done, c_passed;
  logic [2:0]  s_code, c_code;
  logic [5:0]  s_idx, c_idx;
  logic [31:0] s_got, c_got, s_cyc, c_cyc;
  logic [6:0]  s_pcnt, c_pcnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_num [64];
  logic [31:0] m_ans [64];
  int          m_nact;
  logic [31:0] tr_num  [40];
  logic [31:0] tr_out  [40];
  bit          tr_halt [40];
  int          tr_len;

  res_t got_res [2];
  res_t exp_res [2];
  int   got_at  [2];
  int   exp_at  [2];

  riscv_checkpoint_checker #(.NUM_TEST(64), .NW(32), .DW(32), .TIMEOUT_CYCLES(16), .STOP_ON_FAIL(1'b1)) dut_s (
    .CLK(CLK), .RSTn(RSTn), .LD_WE(LD_WE), .LD_IDX(LD_IDX), .LD_NUM(LD_NUM), .LD_ANS(LD_ANS),
    .N_ACT(N_ACT), .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
    .BUSY(s_busy), .DONE(s_done), .PASSED(s_passed), .ERR_CODE(s_code), .ERR_IDX(s_idx),
    .ERR_GOT(s_got), .PASS_CNT(s_pcnt), .CYCLE_CNT(s_cyc));

  riscv_checkpoint_checker #(.NUM_TEST(64), .NW(32), .DW(32), .TIMEOUT_CYCLES(0), .STOP_ON_FAIL(1'b0)) dut_c (
    .CLK(CLK), .RSTn(RSTn), .LD_WE(LD_WE), .LD_IDX(LD_IDX), .LD_NUM(LD_NUM), .LD_ANS(LD_ANS),
    .N_ACT(N_ACT), .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
    .BUSY(c_busy), .DONE(c_done), .PASSED(c_passed), .ERR_CODE(c_code), .ERR_IDX(c_idx),
    .ERR_GOT(c_got), .PASS_CNT(c_pcnt), .CYCLE_CNT(c_cyc));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic snapshot();
    got_res[0] = {s_busy, s_done, s_passed, s_code, s_idx, s_got, s_pcnt, s_cyc};
    got_res[1] = {c_busy, c_done, c_passed, c_code, c_idx, c_got, c_pcnt, c_cyc};
  endtask

  task automatic load(input int idx, input logic [31:0] num, input logic [31:0] ans);
    LD_WE = 1'b1; LD_IDX = 6'(idx); LD_NUM = num; LD_ANS = ans;
    @(negedge CLK);
    LD_WE = 1'b0;
    m_num[idx] = num;
    m_ans[idx] = ans;
  endtask

  task automatic load_spec_table();
    load(0, 32'd4, 32'h0f00);
    load(1, 32'd6, 32'h0018);
    load(2, 32'd8, 32'h001d);
    m_nact = 3;
  endtask

  // Ramp 0..len-1 with correct values at checkpoints, random elsewhere, HALT on the last sample.
  task automatic make_ramp(input int len);
    tr_len = len;
    for (int i = 0; i < len; i++) begin
      tr_num[i]  = i;
      tr_out[i]  = $urandom;
      tr_halt[i] = (i == len - 1);
      for (int j = 0; j < m_nact; j++)
        if (m_num[j] == 32'(i)) tr_out[i] = m_ans[j];
    end
  endtask

  // Reference: walk the trace sample by sample applying the checkpoint rules.
  task automatic predict(input bit stop, input int tmo, output res_t r, output int at);
    int ptr, pc, code, eidx, bad;
    logic [31:0] got;
    int unsigned cyc;
    bit fin, ok;
    ptr = 0; pc = 0; code = 0; eidx = 0; got = '0; cyc = 0; fin = 0; ok = 0; at = -1;
    for (int i = 0; i < tr_len && !fin; i++) begin
      bad = 0;
      cyc++;
      if (ptr < m_nact) begin
        if (tr_num[i] == m_num[ptr]) begin
          if (tr_out[i] == m_ans[ptr]) begin ptr++; pc++; end
          else bad = 1;
        end else if (tr_num[i] > m_num[ptr]) bad = 2;
      end
      if (bad != 0) begin
        if (code == 0) begin code = bad; eidx = ptr; got = tr_out[i]; end
        if (stop) fin = 1; else ptr++;
      end
      if (!fin && tr_halt[i]) begin
        fin = 1;
        ok = (ptr == m_nact) && (code == 0);
        if (!ok && code == 0) begin code = 3; eidx = ptr; got = tr_out[i]; end
      end else if (!fin && tmo != 0 && cyc == tmo) begin
        fin = 1;
        if (code == 0) begin code = 4; eidx = ptr; got = tr_out[i]; end
      end
      if (fin) at = i;
    end
    r = {~fin, fin, fin & ok, 3'(code), 6'(eidx), got, 7'(pc), 32'(cyc)};
  endtask

  // poke >= 0: at that sample also pulse LD_WE and START, both of which RUN must ignore.
  task automatic run_trace(input int poke);
    N_ACT = 7'(m_nact);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    got_at[0] = -1; got_at[1] = -1;
    for (int i = 0; i < tr_len; i++) begin
      NUM_INST = tr_num[i]; OUTPUT_PORT = tr_out[i]; HALT = tr_halt[i];
      if (i == poke) begin
        LD_WE = 1'b1; LD_IDX = 6'd0; LD_NUM = 32'd0; LD_ANS = 32'hffff_ffff; START = 1'b1;
      end
      @(negedge CLK);
      LD_WE = 1'b0; START = 1'b0;
      if (got_at[0] < 0 && s_done) got_at[0] = i;
      if (got_at[1] < 0 && c_done) got_at[1] = i;
    end
    HALT = 1'b0; NUM_INST = '0;
    snapshot();
    predict(1'b1, 16, exp_res[0], exp_at[0]);
    predict(1'b0, 0, exp_res[1], exp_at[1]);
  endtask

  task automatic test_reset();
    snapshot();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: got %h required 0", k, got_res[k]);
      end
    end
  endtask

  task automatic test_pass();
    load_spec_table();
    make_ramp(10);
    run_trace(-1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== exp_res[k] || got_at[k] != exp_at[k]) begin
        errors++;
        $display("FAIL pass_run dut%0d: got %h@%0d expected %h@%0d", k, got_res[k], got_at[k], exp_res[k], exp_at[k]);
      end
      checks++;
      if (got_res[k].passed !== 1'b1 || got_res[k].pcnt !== 7'd3 || got_res[k].code !== 3'd0) begin
        errors++;
        $display("FAIL pass_spec dut%0d: passed %0d pcnt %0d code %0d required 1 3 0", k,
                 got_res[k].passed, got_res[k].pcnt, got_res[k].code);
      end
    end
  endtask

  task automatic test_mismatch();
    make_ramp(10);
    tr_out[6] = 32'h0017;
    run_trace(-1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== exp_res[k] || got_at[k] != exp_at[k]) begin
        errors++;
        $display("FAIL mismatch_run dut%0d: got %h@%0d expected %h@%0d", k, got_res[k], got_at[k], exp_res[k], exp_at[k]);
      end
    end
    checks++;
    if (got_at[0] != 6 || got_res[0].code !== 3'd1 || got_res[0].idx !== 6'd1 ||
        got_res[0].got !== 32'h17 || got_res[0].pcnt !== 7'd1) begin
      errors++;
      $display("FAIL mismatch_stop: at %0d code %0d idx %0d got %h pcnt %0d required 6 1 1 17 1",
               got_at[0], got_res[0].code, got_res[0].idx, got_res[0].got, got_res[0].pcnt);
    end
    checks++;
    if (got_res[1].pcnt !== 7'd2 || got_res[1].code !== 3'd1 || got_res[1].idx !== 6'd1 || got_res[1].passed !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_cont: pcnt %0d code %0d idx %0d passed %0d required 2 1 1 0",
               got_res[1].pcnt, got_res[1].code, got_res[1].idx, got_res[1].passed);
    end
  endtask

  task automatic test_missed();
    make_ramp(10);
    for (int i = 6; i < 9; i++) begin
      tr_num[i] = tr_num[i+1];
      tr_out[i] = tr_out[i+1];
    end
    tr_len = 9;
    tr_halt[8] = 1'b1;
    run_trace(-1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== exp_res[k] || got_at[k] != exp_at[k]) begin
        errors++;
        $display("FAIL missed_run dut%0d: got %h@%0d expected %h@%0d", k, got_res[k], got_at[k], exp_res[k], exp_at[k]);
      end
      checks++;
      if (got_res[k].code !== 3'd2 || got_res[k].idx !== 6'd1) begin
        errors++;
        $display("FAIL missed_spec dut%0d: code %0d idx %0d required 2 1", k, got_res[k].code, got_res[k].idx);
      end
    end
  endtask

  task automatic test_incomplete();
    make_ramp(8);
    run_trace(-1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== exp_res[k] || got_at[k] != exp_at[k]) begin
        errors++;
        $display("FAIL incomplete_run dut%0d: got %h@%0d expected %h@%0d", k, got_res[k], got_at[k], exp_res[k], exp_at[k]);
      end
      checks++;
      if (got_res[k].done !== 1'b1 || got_res[k].passed !== 1'b0 || got_res[k].code !== 3'd3 ||
          got_res[k].idx !== 6'd2 || got_res[k].pcnt !== 7'd2) begin
        errors++;
        $display("FAIL incomplete_spec dut%0d: got %h required done fail code 3 idx 2 pcnt 2", k, got_res[k]);
      end
    end
  endtask

  task automatic test_timeout();
    tr_len = 20;
    for (int i = 0; i < 20; i++) begin
      tr_num[i] = 32'd0; tr_out[i] = $urandom; tr_halt[i] = (i == 19);
    end
    run_trace(-1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== exp_res[k] || got_at[k] != exp_at[k]) begin
        errors++;
        $display("FAIL timeout_run dut%0d: got %h@%0d expected %h@%0d", k, got_res[k], got_at[k], exp_res[k], exp_at[k]);
      end
    end
    checks++;
    if (got_at[0] != 15 || got_res[0].code !== 3'd4 || got_res[0].cyc !== 32'd16) begin
      errors++;
      $display("FAIL timeout_spec: at %0d code %0d cyc %0d required 15 4 16", got_at[0], got_res[0].code, got_res[0].cyc);
    end
  endtask

  task automatic test_empty();
    m_nact = 0;
    make_ramp(5);
    run_trace(-1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== exp_res[k] || got_at[k] != exp_at[k] || got_res[k].passed !== 1'b1) begin
        errors++;
        $display("FAIL empty_run dut%0d: got %h@%0d expected %h@%0d", k, got_res[k], got_at[k], exp_res[k], exp_at[k]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    load_spec_table();
    N_ACT = 7'd3;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      NUM_INST = i; OUTPUT_PORT = (i == 4) ? 32'h0f00 : 32'h0;
      @(negedge CLK);
    end
    RSTn = 1'b0;
    #1;
    snapshot();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== '0) begin
        errors++;
        $display("FAIL mid_run_reset dut%0d: got %h required 0", k, got_res[k]);
      end
    end
    @(negedge CLK);
    RSTn = 1'b1;
    NUM_INST = '0;
    make_ramp(10);
    run_trace(2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_res[k] !== exp_res[k] || got_at[k] != exp_at[k] || got_res[k].passed !== 1'b1) begin
        errors++;
        $display("FAIL restart_run dut%0d: got %h@%0d expected %h@%0d", k, got_res[k], got_at[k], exp_res[k], exp_at[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, base, len, r;
    logic [31:0] v;
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 5);
      base = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        load(j, 32'(base), $urandom);
        base += $urandom_range(1, 4);
      end
      m_nact = n;
      len = $urandom_range(3, 24);
      tr_len = len;
      v = '0;
      for (int i = 0; i < len; i++) begin
        tr_num[i] = v; tr_out[i] = $urandom; tr_halt[i] = (i == len - 1);
        for (int j = 0; j < n; j++)
          if (m_num[j] == v) tr_out[i] = ($urandom_range(0, 9) != 0) ? m_ans[j] : (m_ans[j] ^ 32'h1);
        r = $urandom_range(0, 19);
        v = v + ((r == 0) ? 32'd0 : (r == 1) ? 32'd2 : 32'd1);
      end
      run_trace(-1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_res[k] !== exp_res[k] || got_at[k] != exp_at[k]) begin
          errors++;
          $display("FAIL random_run it%0d dut%0d: got %h@%0d expected %h@%0d", it, k, got_res[k], got_at[k], exp_res[k], exp_at[k]);
        end
      end
    end
  endtask

  initial begin
    RSTn = 1'b0; LD_WE = 1'b0; LD_IDX = '0; LD_NUM = '0; LD_ANS = '0; N_ACT = '0;
    START = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0; m_nact = 0;
    repeat (2) @(negedge CLK);
    test_reset();
    RSTn = 1'b1;
    @(negedge CLK);
    test_reset();
    test_pass();
    test_mismatch();
    test_missed();
    test_incomplete();
    test_timeout();
    test_empty();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
